// File: rtl/mest_pro_seq_ctrl.sv
// MESTPro instruction sequencer: drives the fetch-stage phase strobes,
// decodes the fetched word into branch controls, and handshakes
// multi-cycle ALU operations with the datapath.
module mest_pro_seq_ctrl #(
    parameter int INSTRUCTION_SIZE = 16,
    parameter int OPCODE_SIZE      = 4,
    parameter int CONSTANT_K_SIZE  = 8,
    parameter int EXEC_TIMEOUT     = 255
) (
    input  logic                       clk,
    input  logic                       i_reset_n,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [INSTRUCTION_SIZE-1:0] i_instr,
    input  logic                       i_exec_done,
    output logic                       o_idle_state,
    output logic                       o_fetch_state,
    output logic                       o_exec_state,
    output logic                       o_jump,
    output logic                       o_return_pc,
    output logic [CONSTANT_K_SIZE-1:0] o_const_K,
    output logic [OPCODE_SIZE-1:0]     o_opcode,
    output logic                       o_exec_valid,
    output logic                       o_done,
    output logic                       o_error,
    output logic [15:0]                o_instr_count
);

    localparam int TW = $clog2(EXEC_TIMEOUT + 1);
    localparam logic [OPCODE_SIZE-1:0] OP_JMP  = OPCODE_SIZE'(1);
    localparam logic [OPCODE_SIZE-1:0] OP_RET  = OPCODE_SIZE'(2);
    localparam logic [OPCODE_SIZE-1:0] OP_HALT = OPCODE_SIZE'(3);
    localparam logic [OPCODE_SIZE-1:0] OP_ALU0 = OPCODE_SIZE'(4);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  tmo_cnt;
    logic           is_alu;
    logic           exec_ok;
    logic           exec_tmo;
    logic           start_acc;

    // Opcode class and EXEC exit conditions, all from the latched opcode.
    always_comb begin
        is_alu    = (o_opcode >= OP_ALU0);
        exec_ok   = is_alu ? i_exec_done : 1'b1;
        exec_tmo  = is_alu && !i_exec_done && (tmo_cnt == TW'(EXEC_TIMEOUT - 1));
        start_acc = (state == S_IDLE) && i_start && !i_abort;
    end

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (i_start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = (i_instr[INSTRUCTION_SIZE-1 -: OPCODE_SIZE] == OP_HALT)
                                  ? S_DONE : S_EXEC;
            S_EXEC: begin
                if (exec_ok)       state_nxt = S_FETCH;
                else if (exec_tmo) state_nxt = S_IDLE;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (i_abort) state_nxt = S_IDLE;
    end

    // Output decode: phase strobes and branch/handshake controls.
    always_comb begin
        o_idle_state  = (state == S_IDLE);
        o_fetch_state = (state == S_FETCH);
        o_exec_state  = (state == S_EXEC);
        o_jump        = o_exec_state && (o_opcode == OP_JMP);
        o_return_pc   = o_exec_state && (o_opcode == OP_RET);
        o_exec_valid  = o_exec_state && is_alu && (tmo_cnt == '0);
        o_done        = (state == S_DONE) && !i_abort;
    end

    // Instruction latch, EXEC timeout counter, retire counter and error flag.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_opcode      <= '0;
            o_const_K     <= '0;
            tmo_cnt       <= '0;
            o_instr_count <= '0;
            o_error       <= 1'b0;
        end else begin
            if (state == S_DECODE) begin
                o_opcode  <= i_instr[INSTRUCTION_SIZE-1 -: OPCODE_SIZE];
                o_const_K <= i_instr[CONSTANT_K_SIZE-1:0];
            end
            tmo_cnt <= (state == S_EXEC) ? tmo_cnt + TW'(1) : '0;
            if (start_acc) begin
                o_instr_count <= '0;
                o_error       <= 1'b0;
            end else if (!i_abort) begin
                if (((state == S_EXEC) && exec_ok) || (state == S_DONE))
                    if (o_instr_count != 16'hFFFF)
                        o_instr_count <= o_instr_count + 16'd1;
                if ((state == S_EXEC) && exec_tmo)
                    o_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mest_pro_seq_ctrl.sv
// Directed bench for the MESTPro sequencer: reset, straight-line program,
// branches, exec timeout, abort collisions and asynchronous reset.
module tb_mest_pro_seq_ctrl;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_start;
    logic        i_abort;
    logic [15:0] i_instr;
    logic        i_exec_done;
    logic        o_idle_state, o_fetch_state, o_exec_state;
    logic        o_jump, o_return_pc, o_exec_valid, o_done, o_error;
    logic [7:0]  o_const_K;
    logic [3:0]  o_opcode;
    logic [15:0] o_instr_count;

    int vectors = 0;
    int miscompares = 0;

    mest_pro_seq_ctrl dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_abort(i_abort),
        .i_instr(i_instr), .i_exec_done(i_exec_done),
        .o_idle_state(o_idle_state), .o_fetch_state(o_fetch_state),
        .o_exec_state(o_exec_state), .o_jump(o_jump), .o_return_pc(o_return_pc),
        .o_const_K(o_const_K), .o_opcode(o_opcode), .o_exec_valid(o_exec_valid),
        .o_done(o_done), .o_error(o_error), .o_instr_count(o_instr_count)
    );

    always #5 clk = ~clk;

    // Control bundle {idle,fetch,exec,jump,ret,exec_valid,done,error}
    function automatic logic [7:0] ctl();
        return {o_idle_state, o_fetch_state, o_exec_state, o_jump,
                o_return_pc, o_exec_valid, o_done, o_error};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        i_reset_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_instr = 16'h0000; i_exec_done = 1'b0;
        tick(); tick();
        chk("rst_ctl", 32'(ctl()), 32'h80);
        i_reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ctl", 32'(ctl()), 32'h80);
            chk("idle_regs", {o_instr_count, o_const_K, 4'h0, o_opcode}, 32'h0);
        end

        // Straight line: NOP, ALU (done on 3rd EXEC cycle), HALT
        i_instr = 16'h0000; i_start = 1'b1;
        tick(); chk("sl_f1", 32'(ctl()), 32'h40); i_start = 1'b0;
        tick(); chk("sl_d1", 32'(ctl()), 32'h00);
        tick(); chk("sl_e1", 32'(ctl()), 32'h20);
        i_instr = 16'h4000;
        tick(); chk("sl_f2", 32'(ctl()), 32'h40);
        chk("sl_cnt1", 32'(o_instr_count), 32'd1);
        tick(); chk("sl_d2", 32'(ctl()), 32'h00);
        tick(); chk("sl_e2a", 32'(ctl()), 32'h24);
        chk("sl_op4", 32'(o_opcode), 32'd4);
        tick(); chk("sl_e2b", 32'(ctl()), 32'h20);
        tick(); chk("sl_e2c", 32'(ctl()), 32'h20);
        i_exec_done = 1'b1; i_instr = 16'h3000;
        tick(); i_exec_done = 1'b0;
        chk("sl_f3", 32'(ctl()), 32'h40);
        chk("sl_cnt2", 32'(o_instr_count), 32'd2);
        tick(); chk("sl_d3", 32'(ctl()), 32'h00);
        tick(); chk("sl_done", 32'(ctl()), 32'h02);
        tick(); chk("sl_idle", 32'(ctl()), 32'h80);
        chk("sl_cnt3", 32'(o_instr_count), 32'd3);

        // Branch: JMP 0x25 then RET, leave via abort
        i_instr = 16'h1025; i_start = 1'b1;
        tick(); i_start = 1'b0;
        chk("br_cnt_clr", 32'(o_instr_count), 32'd0);
        tick(); tick();
        chk("br_jmp", 32'(ctl()), 32'h30);
        chk("br_k", 32'(o_const_K), 32'h25);
        i_instr = 16'h2000;
        tick(); chk("br_f", 32'(ctl()), 32'h40);
        tick(); tick();
        chk("br_ret", 32'(ctl()), 32'h28);
        i_abort = 1'b1;
        tick(); i_abort = 1'b0;
        chk("br_abort", 32'(ctl()), 32'h80);
        chk("br_cnt", 32'(o_instr_count), 32'd1);

        // Timeout: ALU with no done
        i_instr = 16'h5000; i_start = 1'b1;
        tick(); i_start = 1'b0;
        tick(); tick();
        chk("to_e1", 32'(ctl()), 32'h24);
        for (int i = 0; i < 254; i++) tick();
        chk("to_e255", 32'(ctl()), 32'h20);
        tick();
        chk("to_err", 32'(ctl()), 32'h81);
        chk("to_cnt", 32'(o_instr_count), 32'd0);
        i_instr = 16'h0000; i_start = 1'b1;
        tick(); i_start = 1'b0;
        chk("to_clr", 32'(ctl()), 32'h40);

        // Abort during ALU EXEC, then abort+start collision in IDLE
        i_instr = 16'h4000;
        tick(); tick();
        chk("ab_e1", 32'(ctl()), 32'h24);
        i_abort = 1'b1;
        tick(); chk("ab_idle", 32'(ctl()), 32'h80);
        chk("ab_cnt", 32'(o_instr_count), 32'd0);
        i_start = 1'b1;
        tick(); chk("ab_coll", 32'(ctl()), 32'h80);
        i_abort = 1'b0; i_start = 1'b0;

        // Async reset in DECODE
        i_instr = 16'h1025; i_start = 1'b1;
        tick(); i_start = 1'b0;
        tick(); chk("ar_dec", 32'(ctl()), 32'h00);
        chk("ar_op_pre", 32'(o_opcode), 32'd4);
        #2 i_reset_n = 1'b0;
        #1 chk("ar_idle", 32'(ctl()), 32'h80);
        chk("ar_op", 32'(o_opcode), 32'd0);
        i_reset_n = 1'b1;
        tick(); chk("ar_stay", 32'(ctl()), 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mest_pro_seq_ctrl.md
# mest_pro_seq_ctrl

Instruction sequencer for the MESTPro core. Generates the one-hot `idle` / `fetch` / `exec` phase strobes that drive the fetch stage, and consumes the fetched instruction word (the fetch stage's `decode_reg`). It decodes that word into branch controls (`jump`, `return_pc`, `const_K`) and handshakes multi-cycle operations with the datapath. It sits directly downstream of the fetch stage and closes the loop back into it.

## Interface
Parameters:
- `INSTRUCTION_SIZE`, 16, instruction word width; opcode is bits [15:12], K is bits [7:0].
- `OPCODE_SIZE`, 4, opcode width.
- `CONSTANT_K_SIZE`, 8, branch target / constant width.
- `EXEC_TIMEOUT`, 255, maximum cycles to wait for `i_exec_done`.

Ports:
- `clk`  in  1  clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  begin program execution; sampled only in IDLE.
- `i_abort`  in  1  synchronous abort; any state → IDLE next cycle.
- `i_instr`  in  INSTRUCTION_SIZE  fetched instruction word (fetch stage `decode_reg`).
- `i_exec_done`  in  1  datapath completion for ALU-class opcodes.
- `o_idle_state`  out  1  IDLE phase strobe.
- `o_fetch_state`  out  1  FETCH phase strobe.
- `o_exec_state`  out  1  EXEC phase strobe.
- `o_jump`  out  1  jump request, valid with `o_exec_state`.
- `o_return_pc`  out  1  return request, valid with `o_exec_state`.
- `o_const_K`  out  CONSTANT_K_SIZE  latched K field.
- `o_opcode`  out  OPCODE_SIZE  latched opcode.
- `o_exec_valid`  out  1  one-cycle start pulse to the datapath.
- `o_done`  out  1  one-cycle pulse when HALT retires.
- `o_error`  out  1  sticky exec-timeout flag.
- `o_instr_count`  out  16  retired-instruction counter, saturating.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, DONE. State is held in a register; phase strobes decode from it.
  - `o_idle_state` = IDLE.
  - `o_fetch_state` = FETCH.
  - `o_exec_state` = EXEC.
  - DECODE and DONE assert no phase strobe.
- IDLE → FETCH when `i_start` = 1. Otherwise stay in IDLE.
- FETCH → DECODE unconditionally. During FETCH the fetch stage loads `decode_reg` and increments its PC.
- DECODE:
  - Latch `o_opcode` ← `i_instr[15:12]` and `o_const_K` ← `i_instr[7:0]`.
  - If opcode = 3 (HALT), go to DONE. Otherwise go to EXEC.
- Opcode classes:
  - 0 NOP: EXEC lasts 1 cycle.
  - 1 JMP: EXEC lasts 1 cycle; `o_jump` = 1.
  - 2 RET: EXEC lasts 1 cycle; `o_return_pc` = 1.
  - 4–15 ALU: EXEC lasts until `i_exec_done`.
- `o_jump` and `o_return_pc` are combinational from the latched opcode, gated by EXEC. They are never both 1.
- ALU EXEC:
  - `o_exec_valid` pulses in the first EXEC cycle only.
  - Leave EXEC in the cycle `i_exec_done` = 1. Done may arrive in the same cycle as `o_exec_valid`.
  - A timeout counter starts at 0 on EXEC entry and increments each EXEC cycle. When it reaches `EXEC_TIMEOUT` without done: set `o_error`, go to IDLE.
- EXEC exit without error → FETCH; `o_instr_count` increments.
- DONE: `o_done` = 1 for that one cycle, `o_instr_count` increments, then → IDLE.
- `o_instr_count` saturates at 0xFFFF. It clears only on reset, or on `i_start` accepted in IDLE.
- `o_error` clears only on reset or on `i_start` accepted in IDLE.
- `i_abort` has priority over every other transition.
  - Next state is IDLE.
  - No `o_done`, no count increment, `o_error` unchanged.
  - Abort in IDLE keeps IDLE and blocks `i_start` in the same cycle.
- `i_start` outside IDLE is ignored.

## Timing
- Reset values:
  - State IDLE, so `o_idle_state` = 1 and `o_fetch_state` = `o_exec_state` = 0.
  - `o_jump` = `o_return_pc` = `o_exec_valid` = `o_done` = `o_error` = 0.
  - `o_opcode` = 0, `o_const_K` = 0, `o_instr_count` = 0.
- `i_start` in cycle n → `o_fetch_state` in cycle n+1.
- Single-cycle instruction: FETCH, DECODE, EXEC = 3 cycles. The next FETCH follows immediately after EXEC.
- ALU instruction with done in EXEC cycle k (k ≥ 1): 2 + k cycles.
- HALT: FETCH, DECODE, DONE, then IDLE in the following cycle.
- `i_instr` is sampled only in DECODE, i.e. the cycle after FETCH, when `decode_reg` holds the new word.
- Reset asserted mid-operation forces IDLE asynchronously. The next fetch then restarts at PC 0 via `o_idle_state`.

## Test plan
- **Reset/idle:** reset then release, `i_start` = 0 for 10 cycles → `o_idle_state` = 1 throughout, all other outputs 0, count 0.
- **Straight line:** words 0x0000, 0x4000 (done on the 3rd EXEC cycle), 0x3000 after `i_start` → strobe sequence F,D,E,F,D,E,E,E,F,D,DONE; `o_exec_valid` pulses once; `o_done` pulses once; `o_instr_count` = 3; then IDLE.
- **Branch:** word 0x1025 → `o_jump` = 1 and `o_const_K` = 0x25 for exactly one EXEC cycle. Then word 0x2000 → `o_return_pc` = 1 for one cycle, `o_jump` = 0.
- **Timeout:** ALU word 0x5000 with `i_exec_done` held 0 → `o_error` = 1 after 255 EXEC cycles, state IDLE, count unchanged. Next `i_start` clears `o_error`.
- **Abort/start collision:** `i_abort` during EXEC of 0x4000 → IDLE next cycle, no count increment. `i_abort` and `i_start` together in IDLE → stays IDLE.
- **Async reset:** assert reset in the DECODE cycle → `o_idle_state` = 1 immediately, `o_opcode` = 0.
